hazard_ctrl: RTL and testbench

Central pipeline hazard controller for the five-stage MIPS core. It compares D-stage source registers and their Tuse against the destination, write-enable and Tnew carried by the D/E, E/M and M/W pipeline registers. From that it produces the stall/flush controls and the forwarding-mux selects. It also owns the multiply/divide busy sequencer that holds HI/LO-accessing instructions in D until the MDU result is ready.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/mdu_seq.sv | 57 +++++
 rtl/hazard_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the MIPS pipeline hazard controller and its MDU busy sequencer.
package cpu_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned T_W   = 2;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  localparam logic [T_W-1:0] TUSE_NEVER = 2'b11;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // A stage produces source r when it writes r and r is not $0.
  function automatic logic reg_match(input logic we, input logic [REG_W-1:0] wa,
                                     input logic [REG_W-1:0] r);
    return we && (wa == r) && (r != '0);
  endfunction

endpackage

// File: rtl/mdu_seq.sv
// Multiply/divide busy sequencer: holds busy_o high for exactly N cycles after a start.
module mdu_seq
  import cpu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start arriving while already busy is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MDU_IDLE: begin
        if (start_i) begin
          cnt_d   = is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d = MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = MDU_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = MDU_IDLE;
      end
    endcase
  end

  assign busy_o = (state_q == MDU_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush and forwarding selects plus MDU busy tracking.
// Optional stall statistics counter enabled with HAZARD_STATS_EN.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RS_D,
  input  logic [REG_W-1:0] RT_D,
  input  logic [T_W-1:0]   TuseRS_D,
  input  logic [T_W-1:0]   TuseRT_D,
  input  logic             MD_D,
  input  logic [REG_W-1:0] WA_E,
  input  logic [REG_W-1:0] WA_M,
  input  logic [REG_W-1:0] WA_W,
  input  logic             GRFWE_E,
  input  logic             GRFWE_M,
  input  logic             GRFWE_W,
  input  logic [T_W-1:0]   Tnew_E,
  input  logic [T_W-1:0]   Tnew_M,
  input  logic [REG_W-1:0] RS_E,
  input  logic [REG_W-1:0] RT_E,
  input  logic [REG_W-1:0] RT_M,
  input  logic             Start_E,
  input  logic             IsDiv_E,
  output logic             Stall,
  output logic             Busy,
  output logic [1:0]       FwdRS_D,
  output logic [1:0]       FwdRT_D,
  output logic [1:0]       FwdRS_E,
  output logic [1:0]       FwdRT_E,
  output logic             FwdRT_M
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      StallCnt
`endif
);

  logic busy;
  logic e_ready, m_ready;
  logic stall_rs, stall_rt, stall_md;

  mdu_seq #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_seq (
    .clk     (clk),
    .reset   (reset),
    .start_i (Start_E),
    .is_div_i(IsDiv_E),
    .busy_o  (busy)
  );

  assign Busy = busy;

  function automatic logic [1:0] pick_fwd(input logic e_hit, input logic m_hit,
                                          input logic w_hit);
    if (e_hit)      return FWD_E;
    else if (m_hit) return FWD_M;
    else if (w_hit) return FWD_W;
    else            return FWD_GRF;
  endfunction

  function automatic logic data_stall(input logic [REG_W-1:0] r, input logic [T_W-1:0] tuse,
                                      input logic we_e, input logic [REG_W-1:0] wa_e,
                                      input logic [T_W-1:0] tnew_e, input logic we_m,
                                      input logic [REG_W-1:0] wa_m, input logic [T_W-1:0] tnew_m);
    if (tuse == TUSE_NEVER) return 1'b0;
    return (reg_match(we_e, wa_e, r) && (tuse < tnew_e)) ||
           (reg_match(we_m, wa_m, r) && (tuse < tnew_m));
  endfunction

  // Only producers whose result already exists may forward.
  assign e_ready = GRFWE_E && (Tnew_E == '0);
  assign m_ready = GRFWE_M && (Tnew_M == '0);

  always_comb begin
    stall_rs = data_stall(RS_D, TuseRS_D, GRFWE_E, WA_E, Tnew_E, GRFWE_M, WA_M, Tnew_M);
    stall_rt = data_stall(RT_D, TuseRT_D, GRFWE_E, WA_E, Tnew_E, GRFWE_M, WA_M, Tnew_M);
    stall_md = MD_D && (Start_E || busy);
    Stall    = stall_rs || stall_rt || stall_md;

    FwdRS_D = pick_fwd(reg_match(e_ready, WA_E, RS_D), reg_match(m_ready, WA_M, RS_D),
                       reg_match(GRFWE_W, WA_W, RS_D));
    FwdRT_D = pick_fwd(reg_match(e_ready, WA_E, RT_D), reg_match(m_ready, WA_M, RT_D),
                       reg_match(GRFWE_W, WA_W, RT_D));
    FwdRS_E = pick_fwd(1'b0, reg_match(m_ready, WA_M, RS_E), reg_match(GRFWE_W, WA_W, RS_E));
    FwdRT_E = pick_fwd(1'b0, reg_match(m_ready, WA_M, RT_E), reg_match(GRFWE_W, WA_W, RT_E));
    FwdRT_M = reg_match(GRFWE_W, WA_W, RT_M);
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset)     stall_cnt_q <= '0;
    else if (Stall) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed plan scenarios plus randomized traffic.
module tb_hazard_ctrl;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] rs_d, rt_d, wa_e, wa_m, wa_w, rs_e, rt_e, rt_m;
  logic [1:0] tuse_rs, tuse_rt, tnew_e, tnew_m;
  logic       md_d, we_e, we_m, we_w, start_e, is_div;
  logic       stall, busy, frt_m;
  logic [1:0] frs_d, frt_d, frs_e, frt_e;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
`endif

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .RS_D(rs_d), .RT_D(rt_d), .TuseRS_D(tuse_rs), .TuseRT_D(tuse_rt), .MD_D(md_d),
    .WA_E(wa_e), .WA_M(wa_m), .WA_W(wa_w),
    .GRFWE_E(we_e), .GRFWE_M(we_m), .GRFWE_W(we_w),
    .Tnew_E(tnew_e), .Tnew_M(tnew_m),
    .RS_E(rs_e), .RT_E(rt_e), .RT_M(rt_m),
    .Start_E(start_e), .IsDiv_E(is_div),
    .Stall(stall), .Busy(busy),
    .FwdRS_D(frs_d), .FwdRT_D(frt_d), .FwdRS_E(frs_e), .FwdRT_E(frt_e),
`ifdef HAZARD_STATS_EN
    .StallCnt(stall_cnt),
`endif
    .FwdRT_M(frt_m)
  );

  typedef struct {
    logic        stall;
    logic        busy;
    logic [1:0]  frs_d, frt_d, frs_e, frt_e;
    logic        frt_m;
    logic [31:0] scnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference state: remaining MDU busy cycles and number of stalled cycles seen.
  int          rem_busy = 0;
  logic [31:0] scnt_m   = '0;

  // Producer table, index 0 = E, 1 = M, 2 = W (W result always available).
  logic [4:0] st_wa[3];
  logic       st_we[3];
  int         st_tn[3];

  function automatic bit produces(input int s, input logic [4:0] r);
    return st_we[s] && st_wa[s] == r && r != 5'd0;
  endfunction

  // Newest available producer, searched from stage 'first' outward; code = stage index + 1.
  function automatic logic [1:0] ref_sel(input logic [4:0] r, input int first);
    for (int s = first; s < 3; s++)
      if (produces(s, r) && st_tn[s] == 0) return 2'(s + 1);
    return 2'd0;
  endfunction

  function automatic bit ref_wait(input logic [4:0] r, input int tuse);
    for (int s = 0; s < 2; s++)
      if (produces(s, r) && tuse < st_tn[s]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Drive one cycle: compute expectation, queue it, then advance the model across the edge.
  task automatic step();
    exp_t e;
    st_wa[0] = wa_e; st_we[0] = we_e; st_tn[0] = int'(tnew_e);
    st_wa[1] = wa_m; st_we[1] = we_m; st_tn[1] = int'(tnew_m);
    st_wa[2] = wa_w; st_we[2] = we_w; st_tn[2] = 0;
    e.busy  = rem_busy > 0;
    e.stall = ref_wait(rs_d, int'(tuse_rs)) || ref_wait(rt_d, int'(tuse_rt)) ||
              (md_d && (start_e || rem_busy > 0));
    e.frs_d = ref_sel(rs_d, 0);
    e.frt_d = ref_sel(rt_d, 0);
    e.frs_e = ref_sel(rs_e, 1);
    e.frt_e = ref_sel(rt_e, 1);
    e.frt_m = ref_sel(rt_m, 2) == 2'd3;
    e.scnt  = scnt_m;
    sb_q.push_back(e);
    @(posedge clk);
    if (!reset) begin
      rem_busy = 0;
      scnt_m   = '0;
    end else begin
      if (e.stall) scnt_m = scnt_m + 32'd1;
      if (rem_busy > 0) rem_busy--;
      else if (start_e) rem_busy = is_div ? int'(DIV_N) : int'(MULT_N);
    end
    #1;
  endtask

  task automatic quiet();
    reset = 1'b1; md_d = 1'b0; start_e = 1'b0; is_div = 1'b0;
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0; rt_m = '0;
    wa_e = '0; wa_m = '0; wa_w = '0; we_e = 1'b0; we_m = 1'b0; we_w = 1'b0;
    tuse_rs = 2'd3; tuse_rt = 2'd3; tnew_e = '0; tnew_m = '0;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      chk("Stall",   32'(stall), 32'(mon_e.stall));
      chk("Busy",    32'(busy),  32'(mon_e.busy));
      chk("FwdRS_D", 32'(frs_d), 32'(mon_e.frs_d));
      chk("FwdRT_D", 32'(frt_d), 32'(mon_e.frt_d));
      chk("FwdRS_E", 32'(frs_e), 32'(mon_e.frs_e));
      chk("FwdRT_E", 32'(frt_e), 32'(mon_e.frt_e));
      chk("FwdRT_M", 32'(frt_m), 32'(mon_e.frt_m));
`ifdef HAZARD_STATS_EN
      chk("StallCnt", stall_cnt, mon_e.scnt);
`endif
    end
  end

  initial begin
    quiet();
    reset = 1'b0;
    @(posedge clk); #1;
    step();
    reset = 1'b1;

    // Load-use: E holds the load, then M, then W forwards.
    quiet(); rs_d = 5'd8; tuse_rs = 2'd1; wa_e = 5'd8; we_e = 1'b1; tnew_e = 2'd2; step();
    we_e = 1'b0; wa_e = '0; tnew_e = '0; wa_m = 5'd8; we_m = 1'b1; tnew_m = 2'd1; step();
    we_m = 1'b0; wa_m = '0; tnew_m = '0; wa_w = 5'd8; we_w = 1'b1; step();

    // ALU forward into E: M beats W.
    quiet(); rt_e = 5'd5; wa_m = 5'd5; we_m = 1'b1; wa_w = 5'd5; we_w = 1'b1; step();

    // $0 never stalls or forwards.
    quiet(); wa_e = '0; we_e = 1'b1; tnew_e = 2'd2; tuse_rs = 2'd0; step();

    // Divide with a HI/LO reader waiting in D.
    quiet(); md_d = 1'b1; start_e = 1'b1; is_div = 1'b1; step();
    start_e = 1'b0;
    repeat (12) step();

    // Reset two cycles into a multiply.
    quiet(); start_e = 1'b1; step();
    start_e = 1'b0; step();
    reset = 1'b0; step();
    reset = 1'b1; md_d = 1'b1;
    repeat (3) step();

    // Stall statistics: three stalled cycles, then reset.
    quiet(); reset = 1'b0; step();
    quiet(); rs_d = 5'd8; tuse_rs = 2'd0; wa_e = 5'd8; we_e = 1'b1; tnew_e = 2'd1;
    repeat (3) step();
    quiet(); step();
    reset = 1'b0; step();
    reset = 1'b1; step();

    // Randomized traffic over a small register window to provoke collisions.
    for (int i = 0; i < 800; i++) begin
      reset   = ($urandom_range(0, 59) != 0);
      rs_d    = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e    = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      rt_m    = 5'($urandom_range(0, 3));
      wa_e    = 5'($urandom_range(0, 3)); wa_m = 5'($urandom_range(0, 3));
      wa_w    = 5'($urandom_range(0, 3));
      we_e    = 1'($urandom_range(0, 1)); we_m = 1'($urandom_range(0, 1));
      we_w    = 1'($urandom_range(0, 1));
      tuse_rs = 2'($urandom_range(0, 3)); tuse_rt = 2'($urandom_range(0, 3));
      tnew_e  = 2'($urandom_range(0, 2)); tnew_m = 2'($urandom_range(0, 1));
      md_d    = ($urandom_range(0, 2) == 0);
      is_div  = 1'($urandom_range(0, 1));
      start_e = (rem_busy == 0) && ($urandom_range(0, 7) == 0);
      step();
    end

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
